// File: rtl/decoder_pkg.sv
// Shared widths, FSM state encoding and the index-to-one-hot helper
// for the one-hot strobe decoder.
package decoder_pkg;
  localparam int IDX_W = 3;
  localparam int OUT_W = 8;
  localparam int CNT_W = 8;

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_ACTIVE = 2'd1,
    ST_GAP    = 2'd2
  } state_t;

  function automatic logic [OUT_W-1:0] onehot(input logic [IDX_W-1:0] idx);
    logic [OUT_W-1:0] r;
    r      = '0;
    r[idx] = 1'b1;
    return r;
  endfunction
endpackage

// File: rtl/onehot_strobe_decoder_if.sv
// Request handshake plus strobe outputs of the one-hot strobe decoder.
// Handshake: a request is taken on a rising edge where in_valid && in_ready;
// in_idx must be stable while in_valid is high; in_ready never depends on in_valid.
interface onehot_strobe_decoder_if;
  import decoder_pkg::*;

  logic             in_valid;
  logic [IDX_W-1:0] in_idx;
  logic             in_ready;
  logic [OUT_W-1:0] y;
  logic             busy;
  logic             done;
  state_t           state;

  modport master (output in_valid, in_idx,
                  input  in_ready, y, busy, done, state);
  modport slave  (input  in_valid, in_idx,
                  output in_ready, y, busy, done, state);
endinterface

// File: rtl/onehot_dec_3to8.sv
// Purely combinational 3-bit index to 8-bit one-hot core.
module onehot_dec_3to8
  import decoder_pkg::*;
(
  input  logic [IDX_W-1:0] idx,
  output logic [OUT_W-1:0] y
);
  assign y = onehot(idx);
endmodule

// File: rtl/onehot_strobe_decoder.sv
// Sequential 3-to-8 strobe decoder: each accepted index drives its one-hot line
// for HOLD cycles, then the bus idles for GAP cycles; one request may wait in a pending slot.
module onehot_strobe_decoder
  import decoder_pkg::*;
#(
  parameter int HOLD = 4,
  parameter int GAP  = 1
) (
  input  logic clk,
  input  logic rst,
  onehot_strobe_decoder_if.slave bus
);
  generate
    if (HOLD < 1 || HOLD > 255 || GAP < 0 || GAP > 255) begin : g_bad_param
      $error("onehot_strobe_decoder: HOLD must be 1..255 and GAP 0..255");
    end
  endgenerate

  localparam logic [CNT_W-1:0] HOLD_M1 = CNT_W'(HOLD - 1);
  localparam logic [CNT_W-1:0] GAP_M1  = CNT_W'((GAP > 0) ? GAP - 1 : 0);

  state_t           state, nxt_state;
  logic [CNT_W-1:0] cnt, nxt_cnt;
  logic [OUT_W-1:0] y_q, nxt_y, dec_y;
  logic             busy_q, done_q, nxt_done;
  logic             pend_valid;
  logic [IDX_W-1:0] pend_idx;
  logic             accept, have_next, load;
  logic [IDX_W-1:0] next_idx;

  assign accept    = bus.in_valid && !pend_valid;
  assign have_next = pend_valid || accept;
  // The pending entry is always older than a new request, so it goes first.
  assign next_idx  = pend_valid ? pend_idx : bus.in_idx;

  onehot_dec_3to8 u_dec (
    .idx (next_idx),
    .y   (dec_y)
  );

  always_comb begin
    nxt_state = state;
    nxt_cnt   = cnt;
    nxt_done  = 1'b0;
    load      = 1'b0;
    case (state)
      ST_IDLE: begin
        if (have_next) load = 1'b1;
      end
      ST_ACTIVE: begin
        if (cnt != '0) begin
          nxt_cnt = cnt - 1'b1;
        end else begin
          nxt_done = 1'b1;
          if (GAP > 0) begin
            nxt_state = ST_GAP;
            nxt_cnt   = GAP_M1;
          end else if (have_next) begin
            load = 1'b1;
          end else begin
            nxt_state = ST_IDLE;
          end
        end
      end
      ST_GAP: begin
        if (cnt != '0)     nxt_cnt   = cnt - 1'b1;
        else if (have_next) load     = 1'b1;
        else                nxt_state = ST_IDLE;
      end
      default: nxt_state = ST_IDLE;
    endcase
    if (load) begin
      nxt_state = ST_ACTIVE;
      nxt_cnt   = HOLD_M1;
    end
    nxt_y = load ? dec_y : ((nxt_state == ST_ACTIVE) ? y_q : '0);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state      <= ST_IDLE;
      cnt        <= '0;
      y_q        <= '0;
      busy_q     <= 1'b0;
      done_q     <= 1'b0;
      pend_valid <= 1'b0;
      pend_idx   <= '0;
    end else begin
      state  <= nxt_state;
      cnt    <= nxt_cnt;
      y_q    <= nxt_y;
      busy_q <= (nxt_state != ST_IDLE);
      done_q <= nxt_done;
      // A load with an empty slot consumes this cycle's request directly.
      if (load && pend_valid) begin
        pend_valid <= 1'b0;
      end else if (accept && !load) begin
        pend_valid <= 1'b1;
        pend_idx   <= bus.in_idx;
      end
    end
  end

  assign bus.in_ready = !pend_valid;
  assign bus.y        = y_q;
  assign bus.busy     = busy_q;
  assign bus.done     = done_q;
  assign bus.state    = state;
endmodule

// File: tb/tb_onehot_strobe_decoder.sv
// Bench for onehot_strobe_decoder: a GAP=1 and a GAP=0 instance, directed
// stimulus with hand-computed tables, and a done-delimited phase scoreboard.
module tb_onehot_strobe_decoder;
  import decoder_pkg::*;

  localparam int HOLD = 4;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  onehot_strobe_decoder_if bus1 ();
  onehot_strobe_decoder_if bus0 ();

  onehot_strobe_decoder #(.HOLD(HOLD), .GAP(1)) dut1 (.clk(clk), .rst(rst), .bus(bus1));
  onehot_strobe_decoder #(.HOLD(HOLD), .GAP(0)) dut0 (.clk(clk), .rst(rst), .bus(bus0));

  int n_total = 0;
  int n_pass  = 0;
  logic [7:0] exp1_q[$];
  logic [7:0] exp0_q[$];
  logic       watch_40 = 1'b0;
  logic       seen_40  = 1'b0;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_total++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got 0x%0h, want 0x%0h at %0t", nm, act, exp, $time);
  endtask

  // ---------------- clock/reset and driver tasks ----------------
  task automatic tick(input int n = 1);
    repeat (n) @(posedge clk);
    #2;
  endtask

  task automatic drv(input bit sel, input logic v, input logic [2:0] idx);
    if (sel) begin bus1.in_valid = v; bus1.in_idx = idx; end
    else     begin bus0.in_valid = v; bus0.in_idx = idx; end
  endtask

  task automatic push(input bit sel, input logic [7:0] e);
    if (sel) exp1_q.push_back(e);
    else     exp0_q.push_back(e);
  endtask

  function automatic logic [9:0] obs(input bit sel);
    return sel ? {bus1.y, bus1.in_ready, bus1.done} : {bus0.y, bus0.in_ready, bus0.done};
  endfunction

  // Request a at c0, b one cycle later; tv holds {y, in_ready, done} seen after c0..c9.
  task automatic run_pair(input bit sel, input logic [2:0] a, input logic [7:0] ea,
                          input logic [2:0] b, input logic [7:0] eb,
                          input logic [9:0] tv[10]);
    drv(sel, 1'b1, a);
    push(sel, ea);
    tick();
    for (int j = 0; j < 10; j++) begin
      chk(sel ? "pair1_obs" : "pair0_obs", {22'd0, obs(sel)}, {22'd0, tv[j]});
      if (j == 0) begin drv(sel, 1'b1, b); push(sel, eb); end
      if (j == 1) drv(sel, 1'b0, 3'd0);
      if (j < 9) tick();
    end
  endtask

  task automatic wait_idle();
    int w;
    for (w = 0; w < 60; w++) begin
      if (!bus1.busy && !bus0.busy && bus1.in_ready && bus0.in_ready) break;
      tick();
    end
    chk("idle_timeout", (w < 60), 1);
  endtask

  task automatic send1(input logic [2:0] idx, input logic [7:0] e);
    logic r;
    logic taken;
    taken = 1'b0;
    drv(1'b1, 1'b1, idx);
    for (int w = 0; w < 50 && !taken; w++) begin
      r = bus1.in_ready;
      if (r) push(1'b1, e);
      tick();
      taken = r;
    end
    drv(1'b1, 1'b0, 3'd0);
    chk("send_timeout", taken, 1);
  endtask

  // ---------------- scoreboard monitor ----------------
  logic [7:0] ph_y[2];
  int         ph_len[2];

  always @(negedge clk) begin
    logic [7:0] yv;
    logic       dv;
    logic [7:0] e;
    for (int k = 0; k < 2; k++) begin
      yv = (k == 0) ? bus0.y : bus1.y;
      dv = (k == 0) ? bus0.done : bus1.done;
      if (rst) begin
        ph_len[k] = 0;
        ph_y[k]   = 8'h00;
      end else begin
        chk("onehot0", {31'd0, $onehot0(yv)}, 1);
        // done closes the phase that ran before this cycle.
        if (dv) begin
          if (k == 0 && exp0_q.size() > 0)      e = exp0_q.pop_front();
          else if (k == 1 && exp1_q.size() > 0) e = exp1_q.pop_front();
          else                                  e = 8'h00;
          chk("phase_y", {24'd0, ph_y[k]}, {24'd0, e});
          chk("phase_len", ph_len[k], HOLD);
          ph_len[k] = 0;
        end
        if (yv != 8'h00) begin
          if (ph_len[k] == 0) begin
            ph_y[k]   = yv;
            ph_len[k] = 1;
          end else begin
            chk("y_stable", {24'd0, yv}, {24'd0, ph_y[k]});
            ph_len[k]++;
          end
        end
        if (k == 1 && watch_40 && yv == 8'h40) seen_40 = 1'b1;
      end
    end
  end

  initial begin
    #300000;
    $display("FAIL watchdog: simulation exceeded time limit");
    $fatal(1, "watchdog");
  end

  // ---------------- stimulus ----------------
  initial begin
    logic [9:0] tv1[10];
    logic [9:0] tv0[10];
    tv1 = '{ {8'h01,1'b1,1'b0}, {8'h01,1'b0,1'b0}, {8'h01,1'b0,1'b0}, {8'h01,1'b0,1'b0},
             {8'h00,1'b0,1'b1}, {8'h80,1'b1,1'b0}, {8'h80,1'b1,1'b0}, {8'h80,1'b1,1'b0},
             {8'h80,1'b1,1'b0}, {8'h00,1'b1,1'b1} };
    tv0 = '{ {8'h04,1'b1,1'b0}, {8'h04,1'b0,1'b0}, {8'h04,1'b0,1'b0}, {8'h04,1'b0,1'b0},
             {8'h08,1'b1,1'b1}, {8'h08,1'b1,1'b0}, {8'h08,1'b1,1'b0}, {8'h08,1'b1,1'b0},
             {8'h00,1'b1,1'b1}, {8'h00,1'b1,1'b0} };

    drv(1'b1, 1'b0, 3'd0);
    drv(1'b0, 1'b0, 3'd0);

    // Reset held two cycles, then ten idle cycles.
    rst = 1'b1;
    tick(2);
    chk("reset_state", {21'd0, bus1.y, bus1.busy, bus1.done, bus1.in_ready},
        {21'd0, 8'h00, 1'b0, 1'b0, 1'b1});
    rst = 1'b0;
    for (int i = 0; i < 10; i++) begin
      tick();
      chk("idle", {19'd0, bus1.y, bus1.busy, bus1.done, bus1.in_ready, bus1.state},
          {19'd0, 8'h00, 1'b0, 1'b0, 1'b1, ST_IDLE});
    end

    // Single request, index 5.
    chk("single_ready", bus1.in_ready, 1);
    drv(1'b1, 1'b1, 3'd5);
    push(1'b1, 8'h20);
    tick();
    drv(1'b1, 1'b0, 3'd0);
    for (int i = 0; i < 4; i++) begin
      chk("single_y", {24'd0, bus1.y}, 32'h20);
      chk("single_busy", bus1.busy, 1);
      tick();
    end
    chk("single_gap", {29'd0, bus1.y == 8'h00, bus1.done, bus1.busy}, {29'd0, 3'b111});
    tick();
    chk("single_end", {30'd0, bus1.busy, bus1.done}, 0);

    // Back-to-back with a one-cycle gap.
    wait_idle();
    run_pair(1'b1, 3'd0, 8'h01, 3'd7, 8'h80, tv1);

    // Back-to-back with no gap.
    wait_idle();
    run_pair(1'b0, 3'd2, 8'h04, 3'd3, 8'h08, tv0);

    // Reset while one request is active and another is pending.
    wait_idle();
    drv(1'b1, 1'b1, 3'd1);
    push(1'b1, 8'h02);
    tick();
    drv(1'b1, 1'b1, 3'd6);
    push(1'b1, 8'h40);
    tick();
    drv(1'b1, 1'b0, 3'd0);
    rst = 1'b1;
    exp1_q.delete();
    exp0_q.delete();
    tick();
    rst = 1'b0;
    chk("midrst_state", {21'd0, bus1.y, bus1.busy, bus1.done, bus1.in_ready},
        {21'd0, 8'h00, 1'b0, 1'b0, 1'b1});
    watch_40 = 1'b1;
    tick(12);
    watch_40 = 1'b0;
    chk("midrst_no_0x40", seen_40, 0);

    // Sweep all indices with random idle gaps between requests.
    for (int i = 0; i < 8; i++) begin
      logic [7:0] e;
      e = 8'h01 << i;
      tick($urandom_range(0, 3));
      send1(i[2:0], e);
    end
    wait_idle();
    tick(2);
    chk("exp1_drained", exp1_q.size(), 0);
    chk("exp0_drained", exp0_q.size(), 0);

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end
endmodule

// File: doc/onehot_strobe_decoder.md
Name: onehot_strobe_decoder

Overview:
- Sequential 3-to-8 decoder. It is the inverse of the team's 8-to-3 one-hot encoder.
- Accepts a 3-bit index over a valid/ready handshake.
- Drives the matching one-hot line of an 8-bit registered strobe bus for HOLD cycles, then optionally idles the bus for GAP cycles.
- A one-entry pending buffer allows back-to-back requests. Used to drive one-hot select/strobe lines from compact index sources.

Parameters:
- HOLD, 4, cycles each one-hot output stays asserted; legal range 1..255.
- GAP, 1, cycles of y=0 forced after each HOLD phase; legal range 0..255.

Ports:
- clk  input  1  single clock, all state updates on rising edge.
- rst  input  1  synchronous, active-high reset.
- in_valid  input  1  index request valid.
- in_idx  input  3  index to decode (0..7).
- in_ready  output  1  block can accept a request this cycle; equals !pend_valid (combinational from register).
- y  output  8  registered one-hot strobe bus, or all-zero.
- busy  output  1  registered; 1 whenever FSM is not IDLE.
- done  output  1  registered one-cycle pulse marking end of a HOLD phase.

Behaviour:
- Interface: one clock (clk); reset rst is synchronous and active-high.
- Reset: y=0, busy=0, done=0, state=IDLE, counter=0, pend_valid=0 (so in_ready=1). Handshakes during the rst-high cycle are ignored.
- Accept: in_valid && in_ready at a rising edge with rst=0.
- FSM states:
  - IDLE: y=0.
  - ACTIVE: y=1<<idx.
  - GAP: y=0.
- Next-item: pend_idx if pend_valid, else the index accepted this cycle (if any).
- IDLE + accept: next cycle ACTIVE, y=1<<in_idx, cnt=HOLD-1. Latency is exactly 1 cycle.
- ACTIVE, cnt!=0: hold y, cnt--.
- ACTIVE, cnt==0: done=1 next cycle. Then:
  - if GAP>0, go to GAP with cnt=GAP-1 and y=0;
  - else if next-item exists, go to ACTIVE with y=1<<next-item and cnt=HOLD-1 (no zero cycle);
  - else go to IDLE with y=0.
- GAP, cnt!=0: cnt--. GAP, cnt==0: go to ACTIVE with next-item if one exists, else IDLE.
- Pending buffer and in_ready:
  - An accept that is not consumed the same edge as next-item is written to the pending buffer (pend_valid=1).
  - Consuming the pending entry clears pend_valid, so in_ready rises the cycle after consumption.
  - Accept + consume on the same edge with the buffer empty: direct bypass, pend_valid stays 0.
  - The buffer is only one entry, so no accept is possible while pend_valid=1. No overflow case exists.
- done: high for exactly one cycle, the first cycle after the last HOLD cycle. It coincides with the first GAP cycle, the first cycle of the next ACTIVE (GAP=0), or the first IDLE cycle.
- busy mirrors state!=IDLE, registered with state.
- Output invariant: y is always one-hot (ACTIVE) or zero (IDLE/GAP), never multi-hot. All 3-bit indices are legal.
- Reset mid-operation: the next cycle shows reset values; the pending entry is discarded; no done pulse is issued for the aborted phase.
- Counter: 8 bits, decrements only; no wrap-around is possible in legal parameter range. Elaboration error if HOLD<1, HOLD>255 or GAP>255.

Decomposition:
- Package decoder_pkg:
  - IDX_W=3, OUT_W=8, CNT_W=8;
  - state enum {IDLE, ACTIVE, GAP};
  - function onehot(idx) returning 8-bit 1<<idx.
- One natural sub-module: onehot_dec_3to8, a purely combinational index-to-one-hot core, instantiated to form next-y. The FSM, counter and pending buffer stay in the top.

Test Plan (HOLD=4, GAP=1 unless stated; cycle n = n-th rising edge after request):
- Reset/idle: hold rst 2 cycles, release with in_valid=0 -> y=0x00, busy=0, done=0, in_ready=1 for 10 cycles.
- Single request: in_idx=5 accepted c0 -> y=0x20 c1-c4; c5 y=0, done=1, busy=1 (GAP); c6 busy=0, done=0.
- Back-to-back: idx=0 at c0, idx=7 at c1 (pended) -> y=0x01 c1-c4, y=0 c5, y=0x80 c6-c9; in_ready=0 c2-c5, 1 from c6; done at c5 and c10.
- GAP=0 build: idx=2 at c0, idx=3 at c1 -> y=0x04 c1-c4, y=0x08 c5-c8 with no zero cycle; done=1 at c5 and c9.
- Mid-operation reset: idx=1 at c0, idx=6 at c1, rst=1 during c2 -> c3 y=0, busy=0, in_ready=1, done=0; no 0x40 ever appears afterwards.
- Exhaustive sweep: idx 0..7 sequentially with random in_valid gaps -> each ACTIVE phase shows y==1<<idx for exactly HOLD cycles; $onehot0(y) holds every cycle; one done per request.
